// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and lane packing helper for the systolic array and its feeder
// Contents:
//   DATA_WIDTH_DEF, SIZE_DEF : default element width and array edge length
//   state_t                  : feeder state encoding (IDLE=0, STREAM=1, FLUSH=2, DONE=3)
//   lane_lsb()               : LSB bit offset of lane k in a packed line (lane 0 at the MSB end)
package systolic_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SIZE_DEF       = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Lane k occupies bits [(size-k)*width-1 -: width]; this returns the bottom bit of that slice.
  function automatic int lane_lsb(input int lane, input int size, input int width);
    return (size - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// rtl/skew_lane_mux.sv - picks the element one lane presents in a given skew step
// Ports:
//   step : step counter t
//   lane : lane index (row for A, column for B)
//   neff : active dimension of the current run
//   vec  : the lane's row (A) or column (B) of the operand buffer, packed with element 0 at the MSB
//   elem : vec[t - lane] when 0 <= t-lane < neff and lane < neff, else 0
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SIZE       = SIZE_DEF,
  parameter int IDX_W      = 3
) (
  input  logic [4:0]                 step,
  input  logic [IDX_W-1:0]           lane,
  input  logic [3:0]                 neff,
  input  logic [SIZE*DATA_WIDTH-1:0] vec,
  output logic [DATA_WIDTH-1:0]      elem
);

  logic [4:0] lane_x;
  logic [4:0] neff_x;
  logic [4:0] idx;
  logic       in_win;

  always_comb begin
    lane_x = 5'(lane);
    neff_x = 5'(neff);
    idx    = step - lane_x;
    // The step>=lane test guards the subtraction: for t<lane idx wraps and must not look valid.
    in_win = (step >= lane_x) && (idx < neff_x) && (lane_x < neff_x);
    elem   = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (in_win && idx == 5'(k)) begin
        elem = vec[lane_lsb(k, SIZE, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand buffers and skewed row/column line driver for the systolic array
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_row/wr_col/wr_data : element load path (wr_sel 0=A, 1=B), IDLE only
//   N, go                           : active dimension and start pulse (N sampled on go)
//   busy                            : high from go acceptance through the done cycle
//   A_row_line, B_column_line       : skewed lanes, lane 0 at the MSB
//   line_valid, START, done         : step valid, array enable, completion pulse
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SIZE       = SIZE_DEF,
  parameter int IDX_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [IDX_W-1:0]           wr_row,
  input  logic [IDX_W-1:0]           wr_col,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [3:0]                 N,
  input  logic                       go,
  output logic                       busy,
  output logic [SIZE*DATA_WIDTH-1:0] A_row_line,
  output logic [SIZE*DATA_WIDTH-1:0] B_column_line,
  output logic                       line_valid,
  output logic                       START,
  output logic                       done
);

  localparam int LW = SIZE * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] a_mem  [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] b_mem  [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] a_view [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] b_view [SIZE][SIZE];
  logic [LW-1:0]         a_row_vec [SIZE];
  logic [LW-1:0]         b_col_vec [SIZE];
  logic [DATA_WIDTH-1:0] a_elem [SIZE];
  logic [DATA_WIDTH-1:0] b_elem [SIZE];
  logic [LW-1:0]         a_line_next;
  logic [LW-1:0]         b_line_next;

  state_t     state;
  logic [4:0] t;
  logic [3:0] neff;
  logic [3:0] n_clip;
  logic [4:0] sel_step;
  logic [3:0] sel_neff;
  logic [4:0] last_step;
  logic [4:0] last_flush;
  logic       wr_hit;

  assign wr_hit = (state == IDLE) && wr_en &&
                  (int'(wr_row) < SIZE) && (int'(wr_col) < SIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
      end
    end else if (wr_hit) begin
      if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
      else        a_mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Step 0 is registered on the same edge that accepts go, so a write landing on that
  // edge is forwarded into the lane muxes to make the first line include it.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        a_view[i][j] = a_mem[i][j];
        b_view[i][j] = b_mem[i][j];
        if (wr_hit && int'(wr_row) == i && int'(wr_col) == j) begin
          if (wr_sel) b_view[i][j] = wr_data;
          else        a_view[i][j] = wr_data;
        end
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      a_row_vec[i] = '0;
      b_col_vec[i] = '0;
      for (int k = 0; k < SIZE; k++) begin
        a_row_vec[i][lane_lsb(k, SIZE, DATA_WIDTH) +: DATA_WIDTH] = a_view[i][k];
        b_col_vec[i][lane_lsb(k, SIZE, DATA_WIDTH) +: DATA_WIDTH] = b_view[k][i];
      end
    end
  end

  // Muxes look one step ahead so the line registers hold step t during cycle go+1+t.
  assign n_clip     = (N > 4'(SIZE)) ? 4'(SIZE) : N;
  assign sel_step   = (state == IDLE) ? 5'd0 : t + 5'd1;
  assign sel_neff   = (state == IDLE) ? n_clip : neff;
  assign last_step  = {neff, 1'b0} - 5'd2;
  assign last_flush = {1'b0, neff} - 5'd1;

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    skew_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIZE       (SIZE),
      .IDX_W      (IDX_W)
    ) u_a_mux (
      .step (sel_step),
      .lane (IDX_W'(g)),
      .neff (sel_neff),
      .vec  (a_row_vec[g]),
      .elem (a_elem[g])
    );
    skew_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIZE       (SIZE),
      .IDX_W      (IDX_W)
    ) u_b_mux (
      .step (sel_step),
      .lane (IDX_W'(g)),
      .neff (sel_neff),
      .vec  (b_col_vec[g]),
      .elem (b_elem[g])
    );
    assign a_line_next[lane_lsb(g, SIZE, DATA_WIDTH) +: DATA_WIDTH] = a_elem[g];
    assign b_line_next[lane_lsb(g, SIZE, DATA_WIDTH) +: DATA_WIDTH] = b_elem[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      t             <= '0;
      neff          <= '0;
      busy          <= 1'b0;
      line_valid    <= 1'b0;
      START         <= 1'b0;
      done          <= 1'b0;
      A_row_line    <= '0;
      B_column_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            neff <= n_clip;
            t    <= '0;
            busy <= 1'b1;
            if (n_clip == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state         <= STREAM;
              line_valid    <= 1'b1;
              START         <= 1'b1;
              A_row_line    <= a_line_next;
              B_column_line <= b_line_next;
            end
          end
        end
        STREAM: begin
          if (t == last_step) begin
            state         <= FLUSH;
            t             <= '0;
            line_valid    <= 1'b0;
            A_row_line    <= '0;
            B_column_line <= '0;
          end else begin
            t             <= t + 5'd1;
            A_row_line    <= a_line_next;
            B_column_line <= b_line_next;
          end
        end
        FLUSH: begin
          if (t == last_flush) begin
            state <= DONE;
            START <= 1'b0;
            done  <= 1'b1;
          end else begin
            t <= t + 5'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int SZ = 6;
  localparam int IW = 3;
  localparam int LW = SZ * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_sel, go;
  logic [IW-1:0] wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic [3:0]    N;
  logic          busy, line_valid, START, done;
  logic [LW-1:0] A_row_line, B_column_line;

  systolic_feeder #(.DATA_WIDTH(DW), .SIZE(SZ), .IDX_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_data       (wr_data),
    .N             (N),
    .go            (go),
    .busy          (busy),
    .A_row_line    (A_row_line),
    .B_column_line (B_column_line),
    .line_valid    (line_valid),
    .START         (START),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          bz, lv, st, dn;
    logic [LW-1:0] a, b;
  } rec_t;

  typedef struct {
    int a0, a1, b0, b1;
    bit bz, lv, st, dn;
  } vec_t;

  rec_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            lv_cnt = 0;
  logic [DW-1:0] ma [SZ][SZ];
  logic [DW-1:0] mb [SZ][SZ];

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      rec_t e;
      e = sb.pop_front();
      tests++;
      if ({busy, line_valid, START, done} !== {e.bz, e.lv, e.st, e.dn} ||
          A_row_line !== e.a || B_column_line !== e.b) begin
        fails++;
        $display("FAIL stream_cycle got bz=%b lv=%b st=%b dn=%b a=%h b=%h need bz=%b lv=%b st=%b dn=%b a=%h b=%h",
                 busy, line_valid, START, done, A_row_line, B_column_line,
                 e.bz, e.lv, e.st, e.dn, e.a, e.b);
      end
    end
    if (line_valid) lv_cnt++;
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h need=%h", name, got, want);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
  endtask

  // Expected per-cycle outputs of one run, starting the cycle after go is sampled.
  task automatic push_run(input int n, input int keep);
    int   ne;
    int   d;
    rec_t r;
    rec_t lst[$];
    ne = (n > SZ) ? SZ : n;
    for (int t = 0; t <= 2 * ne - 2; t++) begin
      r = '{bz: 1'b1, lv: 1'b1, st: 1'b1, dn: 1'b0, a: '0, b: '0};
      for (int i = 0; i < ne; i++) begin
        d = t - i;
        if (d >= 0 && d < ne) begin
          r.a[(SZ - i) * DW - 1 -: DW] = ma[i][d];
          r.b[(SZ - i) * DW - 1 -: DW] = mb[d][i];
        end
      end
      lst.push_back(r);
    end
    for (int f = 0; f < ne; f++) lst.push_back('{bz: 1'b1, lv: 1'b0, st: 1'b1, dn: 1'b0, a: '0, b: '0});
    lst.push_back('{bz: 1'b1, lv: 1'b0, st: 1'b0, dn: 1'b1, a: '0, b: '0});
    lst.push_back('{bz: 1'b0, lv: 1'b0, st: 1'b0, dn: 1'b0, a: '0, b: '0});
    for (int k = 0; k < lst.size(); k++)
      if (keep < 0 || k < keep) sb.push_back(lst[k]);
  endtask

  task automatic do_write(input bit sel, input int row, input int col, input logic [DW-1:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = IW'(row);
    wr_col  = IW'(col);
    wr_data = d;
    if (accept) begin
      if (sel) mb[row][col] = d;
      else     ma[row][col] = d;
    end
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic do_go(input int n, input int keep);
    go = 1'b1;
    N  = 4'(n);
    push_run(n, keep);
    cycle();
    go    = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) cycle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending need=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    rec_t r;
    int   lv0;
    int   dn_seen;

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; N = '0; go = 1'b0;
    clear_model();
    #3;
    check("reset_flags", LW'({busy, line_valid, START, done}), '0);
    check("reset_a", A_row_line, '0);
    check("reset_b", B_column_line, '0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // N=2 worked example, table driven
    do_write(0, 0, 0, 1, 1); do_write(0, 0, 1, 2, 1);
    do_write(0, 1, 0, 3, 1); do_write(0, 1, 1, 4, 1);
    do_write(1, 0, 0, 5, 1); do_write(1, 0, 1, 6, 1);
    do_write(1, 1, 0, 7, 1); do_write(1, 1, 1, 8, 1);
    tbl[0] = '{1, 0, 5, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{2, 3, 7, 6, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{0, 4, 0, 8, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    go = 1'b1;
    N  = 4'd2;
    for (int k = 0; k < 7; k++) begin
      r = '{bz: tbl[k].bz, lv: tbl[k].lv, st: tbl[k].st, dn: tbl[k].dn, a: '0, b: '0};
      r.a[LW - 1 -: DW]      = DW'(tbl[k].a0);
      r.a[LW - DW - 1 -: DW] = DW'(tbl[k].a1);
      r.b[LW - 1 -: DW]      = DW'(tbl[k].b0);
      r.b[LW - DW - 1 -: DW] = DW'(tbl[k].b1);
      sb.push_back(r);
    end
    lv0 = lv_cnt;
    cycle();
    go = 1'b0;
    wait_drain();
    check("n2_valid_cycles", LW'(lv_cnt - lv0), LW'(3));

    // N=6 full load with spot checks at step 5
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        do_write(0, i, j, DW'(10 * i + j), 1);
        do_write(1, i, j, DW'(100 + 10 * i + j), 1);
      end
    lv0 = lv_cnt;
    do_go(6, -1);
    repeat (5) @(negedge clk);
    #2;
    check("n6_s5_a_lane0_msb", LW'(A_row_line[LW - 1 -: DW]), LW'(5));
    check("n6_s5_a_lane5", LW'(A_row_line[DW - 1:0]), LW'(50));
    check("n6_s5_b_lane5", LW'(B_column_line[DW - 1:0]), LW'(105));
    cycle();
    wait_drain();
    check("n6_valid_cycles", LW'(lv_cnt - lv0), LW'(11));

    // N above SIZE clamps to SIZE
    lv0 = lv_cnt;
    do_go(9, -1);
    wait_drain();
    check("n9_valid_cycles", LW'(lv_cnt - lv0), LW'(11));

    // N=0: done in the cycle after go, nothing valid
    lv0 = lv_cnt;
    do_go(0, -1);
    wait_drain();
    check("n0_valid_cycles", LW'(lv_cnt - lv0), LW'(0));

    // out-of-range and busy writes are dropped, go during STREAM ignored
    do_write(0, 7, 0, 99, 0);
    do_write(1, 0, 7, 99, 0);
    do_write(0, 6, 1, 99, 0);
    do_go(2, -1);
    do_write(0, 0, 1, 555, 0);
    do_write(1, 1, 1, 555, 0);
    go = 1'b1;
    N  = 4'd6;
    cycle();
    go = 1'b0;
    wait_drain();
    do_go(2, -1);
    wait_drain();

    // back-to-back: go in the IDLE cycle right after DONE
    do_go(2, -1);
    repeat (6) cycle();
    do_go(2, -1);
    wait_drain();

    // write in the same cycle as go is streamed
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd1; wr_col = 3'd0; wr_data = 77;
    ma[1][0] = 77;
    do_go(2, -1);
    wait_drain();

    // reset mid-STREAM at step 2
    do_go(3, 2);
    cycle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_flags", LW'({busy, line_valid, START, done}), '0);
    check("midrst_a", A_row_line, '0);
    check("midrst_b", B_column_line, '0);
    clear_model();
    sb.delete();
    repeat (2) cycle();
    rst = 1'b0;
    dn_seen = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (done) dn_seen++;
    end
    check("midrst_no_done", LW'(dn_seen), '0);
    do_go(3, -1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
